// File: rtl/cpu_types_pkg.sv
// Shared types and sizing constants for the reorder buffer.
//   ROB_DEPTH   - number of ROB entries (power of two)
//   ROB_TAG_W   - ROB tag width, log2(ROB_DEPTH)
//   PREG_W      - physical register index width
//   rob_entry_t - per-entry bookkeeping held by the ROB
package cpu_types_pkg;

    localparam int unsigned ROB_DEPTH = 64;
    localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int unsigned PREG_W    = 6;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              rd_used;
        logic [PREG_W-1:0] old_p;
        logic              is_branch;
        logic              mispredict;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates one tag per renamed instruction, records completions
// from the CDB and retires the head entry in order, returning the old physical
// destination to the free list. A retiring mispredicted branch flushes the ROB.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_valid_i/ready_o    allocation handshake from Rename
//   alloc_tag_o              tag for the allocating instruction (current tail)
//   alloc_rd_used_i          instruction writes an architectural register
//   alloc_rd_old_p_i         previous physical mapping of rd
//   alloc_is_branch_i        instruction is a branch
//   complete_valid_i/tag_i   completion broadcast
//   complete_mispredict_i    completing branch was mispredicted
//   commit_valid_o/tag_o     head instruction retires this cycle
//   commit_free_valid_o      commit_free_preg_o returns to the free list
//   commit_free_preg_o       old physical register being freed
//   recover_o                flush pulse to Rename and Dispatch
//   count_o                  current occupancy
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH = cpu_types_pkg::ROB_DEPTH,
    parameter int unsigned TAG_W     = cpu_types_pkg::ROB_TAG_W,
    parameter int unsigned PREG_W    = cpu_types_pkg::PREG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              alloc_rd_used_i,
    input  logic [PREG_W-1:0] alloc_rd_old_p_i,
    input  logic              alloc_is_branch_i,
    input  logic              complete_valid_i,
    input  logic [TAG_W-1:0]  complete_tag_i,
    input  logic              complete_mispredict_i,
    output logic              commit_valid_o,
    output logic [TAG_W-1:0]  commit_tag_o,
    output logic              commit_free_valid_o,
    output logic [PREG_W-1:0] commit_free_preg_o,
    output logic              recover_o,
    output logic [TAG_W:0]    count_o
);

    import cpu_types_pkg::rob_entry_t;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_DEPTH);

    rob_entry_t       rob_q [ROB_DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [TAG_W:0]   count_q;

    logic commit_valid;
    logic recover;
    logic alloc_ready;
    logic alloc_fire;
    logic complete_fire;

    // Everything here depends on registered state except the fire terms, which
    // only feed the state update.
    always_comb begin
        commit_valid  = rob_q[head_q].valid && rob_q[head_q].done;
        recover       = commit_valid && rob_q[head_q].mispredict;
        alloc_ready   = (count_q != FULL_COUNT) && !recover;
        alloc_fire    = alloc_valid_i && alloc_ready;
        // An entry allocated this cycle is not valid yet, so a same-cycle
        // completion to it falls out here naturally.
        complete_fire = complete_valid_i && !recover && rob_q[complete_tag_i].valid;
    end

    // Outputs are forced to their idle values while rst is held so a reset
    // arriving mid-operation never leaks a commit or free pulse.
    always_comb begin
        alloc_ready_o       = rst || alloc_ready;
        alloc_tag_o         = rst ? '0 : tail_q;
        commit_valid_o      = !rst && commit_valid;
        commit_tag_o        = rst ? '0 : head_q;
        commit_free_valid_o = !rst && commit_valid && rob_q[head_q].rd_used;
        commit_free_preg_o  = commit_free_valid_o ? rob_q[head_q].old_p : '0;
        recover_o           = !rst && recover;
        count_o             = rst ? '0 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst || recover) begin
            // A retiring mispredict discards every younger entry at once.
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                rob_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (complete_fire) begin
                rob_q[complete_tag_i].done       <= 1'b1;
                rob_q[complete_tag_i].mispredict <= complete_mispredict_i &&
                                                    rob_q[complete_tag_i].is_branch;
            end
            if (commit_valid) begin
                rob_q[head_q].valid <= 1'b0;
                head_q              <= head_q + TAG_W'(1);
            end
            // head != tail whenever both fire (count is neither 0 nor full).
            if (alloc_fire) begin
                rob_q[tail_q] <= '{valid:      1'b1,
                                   done:       1'b0,
                                   rd_used:    alloc_rd_used_i,
                                   old_p:      alloc_rd_old_p_i,
                                   is_branch:  alloc_is_branch_i,
                                   mispredict: 1'b0};
                tail_q        <= tail_q + TAG_W'(1);
            end
            count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_valid_i;
    logic       alloc_ready_o;
    logic [5:0] alloc_tag_o;
    logic       alloc_rd_used_i;
    logic [5:0] alloc_rd_old_p_i;
    logic       alloc_is_branch_i;
    logic       complete_valid_i;
    logic [5:0] complete_tag_i;
    logic       complete_mispredict_i;
    logic       commit_valid_o;
    logic [5:0] commit_tag_o;
    logic       commit_free_valid_o;
    logic [5:0] commit_free_preg_o;
    logic       recover_o;
    logic [6:0] count_o;

    int vectors = 0;
    int miscompares = 0;

    reorder_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .alloc_valid_i         (alloc_valid_i),
        .alloc_ready_o         (alloc_ready_o),
        .alloc_tag_o           (alloc_tag_o),
        .alloc_rd_used_i       (alloc_rd_used_i),
        .alloc_rd_old_p_i      (alloc_rd_old_p_i),
        .alloc_is_branch_i     (alloc_is_branch_i),
        .complete_valid_i      (complete_valid_i),
        .complete_tag_i        (complete_tag_i),
        .complete_mispredict_i (complete_mispredict_i),
        .commit_valid_o        (commit_valid_o),
        .commit_tag_o          (commit_tag_o),
        .commit_free_valid_o   (commit_free_valid_o),
        .commit_free_preg_o    (commit_free_preg_o),
        .recover_o             (recover_o),
        .count_o               (count_o)
    );

    always #5 clk = ~clk;

    // Reference model: the ROB as an ordered list of in-flight instructions.
    typedef struct {
        int tag;
        bit rd_used;
        int old_p;
        bit br;
        bit done;
        bit mp;
    } m_ent_t;

    m_ent_t mq[$];
    int     m_head;

    typedef struct {
        logic       av;
        logic [5:0] op;
        logic       cv;
        logic [5:0] ct;
        logic       e_ready;
        logic [5:0] e_atag;
        logic       e_cv;
        logic [5:0] e_ctag;
        logic       e_fv;
        logic [5:0] e_fp;
        logic       e_rec;
        logic [6:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic ru, input logic [5:0] op, input logic br,
                         input logic cv, input logic [5:0] ct, input logic cm);
        alloc_valid_i         = av;
        alloc_rd_used_i       = ru;
        alloc_rd_old_p_i      = op;
        alloc_is_branch_i     = br;
        complete_valid_i      = cv;
        complete_tag_i        = ct;
        complete_mispredict_i = cm;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_head = 0;
        #1;
    endtask

    task automatic chk_idle(input string pfx);
        chk({pfx, "_ready"}, alloc_ready_o, 1);
        chk({pfx, "_atag"}, alloc_tag_o, 0);
        chk({pfx, "_commit"}, commit_valid_o, 0);
        chk({pfx, "_ctag"}, commit_tag_o, 0);
        chk({pfx, "_fvalid"}, commit_free_valid_o, 0);
        chk({pfx, "_fpreg"}, commit_free_preg_o, 0);
        chk({pfx, "_recover"}, recover_o, 0);
        chk({pfx, "_count"}, count_o, 0);
    endtask

    // One clock with model checking of every output before the edge.
    task automatic step(input logic av, input logic ru, input logic [5:0] op, input logic br,
                        input logic cv, input logic [5:0] ct, input logic cm);
        int sz, new_tag;
        bit e_cv, e_rec, e_ready, e_fv;
        int e_fp;
        drive(av, ru, op, br, cv, ct, cm);
        #1;
        sz      = mq.size();
        e_cv    = (sz > 0) && mq[0].done;
        e_rec   = e_cv && mq[0].mp;
        e_ready = (sz != DEPTH) && !e_rec;
        e_fv    = e_cv && mq[0].rd_used;
        e_fp    = e_fv ? mq[0].old_p : 0;
        new_tag = (m_head + sz) % DEPTH;
        chk("m_ready", alloc_ready_o, e_ready);
        chk("m_atag", alloc_tag_o, new_tag);
        chk("m_commit", commit_valid_o, e_cv);
        chk("m_ctag", commit_tag_o, m_head);
        chk("m_fvalid", commit_free_valid_o, e_fv);
        chk("m_fpreg", commit_free_preg_o, e_fp);
        chk("m_recover", recover_o, e_rec);
        chk("m_count", count_o, sz);
        @(posedge clk);
        #1;
        if (e_rec) begin
            mq.delete();
            m_head = 0;
        end else begin
            if (cv) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(ct)) begin
                        mq[i].done = 1;
                        mq[i].mp   = cm && mq[i].br;
                    end
                end
            end
            if (e_cv) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (av && e_ready) begin
                mq.push_back('{tag: new_tag, rd_used: ru, old_p: int'(op), br: br,
                               done: 0, mp: 0});
            end
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [5:0] op, input logic cv,
                                input logic [5:0] ct, input logic e_ready,
                                input logic [5:0] e_atag, input logic e_cv,
                                input logic [5:0] e_ctag, input logic e_fv,
                                input logic [5:0] e_fp, input logic [6:0] e_cnt);
        vec_t v;
        v.av = av; v.op = op; v.cv = cv; v.ct = ct;
        v.e_ready = e_ready; v.e_atag = e_atag; v.e_cv = e_cv; v.e_ctag = e_ctag;
        v.e_fv = e_fv; v.e_fp = e_fp; v.e_rec = 1'b0; v.e_cnt = e_cnt;
        return v;
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        // In-order retirement of out-of-order completions (2, 0, 1).
        //            av op  cv ct  rdy atag cv ctag fv fp  cnt
        vecs.push_back(mk(1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 11, 0, 0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 12, 0, 0, 1, 2, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 1, 2, 1, 3, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 1, 1, 1, 3, 1, 0, 1, 10, 3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 1, 1, 11, 2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 2, 1, 12, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 0));

        do_reset();
        chk_idle("rst");
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].av, 1, vecs[i].op, 0, vecs[i].cv, vecs[i].ct, 0);
            #1;
            chk("t_ready", alloc_ready_o, vecs[i].e_ready);
            chk("t_atag", alloc_tag_o, vecs[i].e_atag);
            chk("t_commit", commit_valid_o, vecs[i].e_cv);
            chk("t_ctag", commit_tag_o, vecs[i].e_ctag);
            chk("t_fvalid", commit_free_valid_o, vecs[i].e_fv);
            chk("t_fpreg", commit_free_preg_o, vecs[i].e_fp);
            chk("t_recover", recover_o, vecs[i].e_rec);
            chk("t_count", count_o, vecs[i].e_cnt);
            @(posedge clk);
            #1;
        end

        // Fill to capacity, then retire the head and wrap the tail.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 1, 6'(i), 0, 0, 0, 0);
        chk("full_count", count_o, 64);
        chk("full_ready", alloc_ready_o, 0);
        step(1, 1, 6'd7, 0, 1, 6'd0, 0);
        chk("full_commit", commit_valid_o, 1);
        chk("full_ctag", commit_tag_o, 0);
        chk("full_ready_commit", alloc_ready_o, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_ready", alloc_ready_o, 1);
        chk("wrap_atag", alloc_tag_o, 0);
        chk("wrap_count", count_o, 63);

        // Commit of an instruction without a destination register.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 6'(i + 1), 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 6'(i), 0);
        repeat (6) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 6'd33, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6'd5, 0);
        chk("nord_commit", commit_valid_o, 1);
        chk("nord_ctag", commit_tag_o, 5);
        chk("nord_fvalid", commit_free_valid_o, 0);
        chk("nord_fpreg", commit_free_preg_o, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Mispredicted branch at the head flushes the younger instructions.
        do_reset();
        step(1, 1, 6'd20, 1, 0, 0, 0);
        step(1, 1, 6'd21, 0, 0, 0, 0);
        step(1, 1, 6'd22, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6'd1, 0);
        step(0, 0, 0, 0, 1, 6'd2, 0);
        step(0, 0, 0, 0, 1, 6'd0, 1);
        chk("mp_recover", recover_o, 1);
        chk("mp_commit", commit_valid_o, 1);
        chk("mp_ctag", commit_tag_o, 0);
        chk("mp_fpreg", commit_free_preg_o, 20);
        chk("mp_ready", alloc_ready_o, 0);
        step(1, 1, 6'd23, 0, 1, 6'd1, 0);
        chk("mp_count_after", count_o, 0);
        chk("mp_atag_after", alloc_tag_o, 0);
        chk("mp_commit_after", commit_valid_o, 0);
        chk("mp_recover_after", recover_o, 0);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);

        // Simultaneous allocate and commit; completion to an empty slot.
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, 6'(i + 40), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6'd0, 0);
        chk("sim_count_before", count_o, 10);
        chk("sim_commit", commit_valid_o, 1);
        step(1, 1, 6'd50, 0, 0, 0, 0);
        chk("sim_count_after", count_o, 10);
        step(0, 0, 0, 0, 1, 6'd40, 0);
        chk("inv_count", count_o, 10);
        chk("inv_atag", alloc_tag_o, 11);
        chk("inv_commit", commit_valid_o, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset while the head is done: no commit or free pulse escapes.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 6'(i + 1), 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6'd2, 0);
        step(0, 0, 0, 0, 1, 6'd0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_idle("rst_mid");
        @(posedge clk);
        #1;
        chk_idle("rst_hold");
        rst = 1'b0;
        #1;
        mq.delete();
        m_head = 0;
        chk_idle("rst_after");
        repeat (2) step(0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic       av, ru, br, cv, cm;
            logic [5:0] op, ct;
            int         burst;
            burst = (n / 300) % 2;
            av = ($urandom_range(0, 9) < 7);
            ru = $urandom_range(0, 3) != 0;
            op = 6'($urandom);
            br = $urandom_range(0, 3) == 0;
            cv = burst ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                ct = 6'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                ct = 6'($urandom);
            cm = $urandom_range(0, 15) == 0;
            step(av, ru, op, br, cv, ct, cm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
